muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Sequential multiply/divide unit that owns the HI/LO register pair used by `MFHI`/`MFLO`. The decode stage issues a MULT/MULTU/DIV/DIVU operation with a one-cycle start pulse. The unit iterates one bit per cycle, writes the 64-bit product or the quotient/remainder into HI/LO, and signals completion with a one-cycle `done` pulse. It sits beside the combinational ALU, and the pipeline stalls on `busy`.

## Interface
- `ITER`, default 32: iteration count. It equals the operand width and is fixed at 32.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: issue request; sampled only while idle.
- `op`  in  2: operation. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a`, `b`  in  32: operands, captured on the accepting edge.
- `hi_we`, `lo_we`  in  1: MTHI/MTLO write enables.
- `wdata`  in  32: MTHI/MTLO write data.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle completion pulse.
- `dbz`  out  1: divide-by-zero flag, valid while `done` is high.
- `hi`, `lo`  out  32: architectural HI/LO registers.

## Operation
- States: IDLE, RUN, FIX. `busy` = (state != IDLE).
- **IDLE, `start` = 1:** latch `op`.
  - Signed ops: latch |a| and |b|, and record the sign of the result and the sign of the dividend.
  - Unsigned ops: latch `a` and `b` unchanged.
  - Clear the iteration counter and go to RUN.
- **RUN, multiply:** shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- **RUN, divide:** restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- **RUN exit:** after `ITER` iterations, go to FIX.
- **FIX:** apply sign fix-up, then write HI/LO. Go to IDLE and pulse `done` in the following cycle.
  - Multiply: the product is negated if the signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, carrying the dividend's sign (truncating division, same as Verilog `%` on signed values).
- **Divide by zero (`b` = 0):** still runs the full `ITER` cycles.
  - HI = `a` (original, unsigned view), LO = 32'hFFFFFFFF, `dbz` = 1 with `done`.
  - `dbz` = 0 for all other results.
- **Signed DIV, 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. No trap and no flag.
- **MTHI/MTLO:**
  - In IDLE, `hi_we`/`lo_we` write `wdata` on the edge.
  - While `busy`, writes are dropped.
  - A write together with an accepted `start` takes effect, and is later overwritten by the operation's result.
- **Start while busy:** ignored, with no queuing. The issuer must wait for `done`.
- HI/LO hold their values except on FIX and on IDLE writes.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `dbz` = 0, state = IDLE.
- **Reset mid-operation:** immediate abort to the reset values. No partial write to HI/LO.
- **Latency:** `start` sampled at edge E0, RUN over edges E1..E32, FIX at edge E33.
  - `done` is high and HI/LO are valid in the cycle after E33.
  - `busy` is high in the cycles between E0 and E33.
- **Back-to-back:** a new `start` may be asserted in the same cycle as `done` and is accepted on that edge. This gives a throughput of one operation per 34 cycles.
- `done` and `dbz` are registered outputs, high for exactly one cycle.
- Operands may change after the accepting edge without affecting the result.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:** MULT/MULTU use a single-cycle 32x32 combinational multiplier.
  - IDLE goes straight to FIX (product registered at E1).
  - `done` is high in the cycle after E1, so `busy` is high for 1 cycle.
  - Division timing is unchanged.
- **`MULDIV_FAST_MUL_EN` undefined:** all four ops use the 32-iteration path described above. No multiplier primitive is inferred.

## Test plan
- **Signed DIV:** `a` = 0xFFFFFFF9 (-7), `b` = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, `dbz` = 0. `done` exactly 34 cycles after `start`, with `busy` high in between.
- **Multiply:**
  - MULT `a` = 0x80000000, `b` = 0xFFFFFFFF -> HI = 0x00000000, LO = 0x80000000.
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
  - Repeat both with `MULDIV_FAST_MUL_EN`: same values, `done` 2 cycles after `start`.
- **DIVU by zero:** `a` = 0x64, `b` = 0 -> HI = 0x64, LO = 0xFFFFFFFF, `dbz` = 1 for one cycle. The next DIV 100 / 7 gives `dbz` = 0, LO = 14, HI = 2.
- **Busy interactions:**
  - `start` with different operands and `hi_we` (`wdata` = 0xDEADBEEF) while busy -> both ignored, and the original result lands.
  - MTLO 0x1234 while idle -> LO = 0x1234 on the next cycle.
- **Reset mid-operation:** deassert `rst_n` during RUN iteration 10 -> outputs go to zero asynchronously and no `done` appears. After release, a fresh DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Random regression:** 100 random signed/unsigned pairs issued back-to-back (`start` in the `done` cycle), checked against the reference model.
  - Signed: `$signed` `/`, `%`, `*`.
  - Unsigned: plain `/`, `%`, `*`.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// Handshake and HI/LO bus of the multiply/divide unit; the issuing stage is the
// master and muldiv_hilo is the slave.
interface muldiv_hilo_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, dbz, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, dbz, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair (one bit per cycle).
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for MULT/MULTU.
module muldiv_hilo #(
   parameter int ITER = 32
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_hilo_if.slave bus
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic [63:0]     acc_q, acc_d;
   logic [31:0]     rem_q, rem_d;
   logic [31:0]     opb_q, opb_d;
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;
   logic            bzero_q, bzero_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;

   // Operand preparation: signed ops work on magnitudes and remember the signs.
   logic        in_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   assign in_signed = ~bus.op[0];
   assign a_neg     = in_signed & bus.a[31];
   assign b_neg     = in_signed & bus.b[31];
   assign a_mag     = a_neg ? (~bus.a + 32'd1) : bus.a;
   assign b_mag     = b_neg ? (~bus.b + 32'd1) : bus.b;

   // Iteration datapath: acc_q low half is the multiplier / dividend shift register.
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_trial;

   assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
   assign div_shift = {rem_q, acc_q[31]};
   assign div_trial = div_shift - {1'b0, opb_q};

   // Sign fix-up of the finished result.
   logic [63:0] prod_mag;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

`ifdef MULDIV_FAST_MUL_EN
   assign prod_mag = {32'd0, acc_q[31:0]} * {32'd0, opb_q};
`else
   assign prod_mag = acc_q;
`endif
   assign prod_fix = neg_res_q ? (~prod_mag + 64'd1) : prod_mag;
   assign quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_fix  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

   always_comb begin
      // NOTE: every signal gets its hold/default value first so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      opb_d     = opb_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
            if (bus.start) begin
               is_div_d  = bus.op[1];
               acc_d     = {32'd0, a_mag};
               opb_d     = b_mag;
               rem_d     = 32'd0;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               bzero_d   = (bus.b == 32'd0);
               cnt_d     = '0;
               state_d   = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
               if (!bus.op[1]) state_d = S_FIX;
`endif
            end
         end

         S_RUN: begin
            if (is_div_q) begin
               if (div_trial[32]) begin
                  rem_d = div_shift[31:0];
                  acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
               end else begin
                  rem_d = div_trial[31:0];
                  acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
               end
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
         end

         S_FIX: begin
            if (is_div_q) begin
               // With a zero divisor every trial succeeds: remainder is |a|, which the
               // dividend-sign fix turns back into the original a.
               hi_d  = rem_fix;
               lo_d  = bzero_q ? 32'hFFFF_FFFF : quot_fix;
               dbz_d = bzero_q;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         acc_q     <= '0;
         rem_q     <= '0;
         opb_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         opb_q     <= opb_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.dbz  = dbz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed cases plus a randomized back-to-back
// regression against a 64-bit arithmetic reference model.
module tb_muldiv_hilo;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   muldiv_hilo_if bus_if ();

   muldiv_hilo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference results from plain 64-bit arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic d);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      d  = 1'b0;
      h  = '0;
      l  = '0;
      if (op[1] && b == 32'd0) begin
         h = a;
         l = 32'hFFFF_FFFF;
         d = 1'b1;
      end else begin
         case (op)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            2'b10: begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
            default: begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
         endcase
      end
   endtask

   function automatic int exp_latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) return 2;
`endif
      return 34;
   endfunction

   // Issue one operation at a negedge and return at the negedge of the done cycle.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      logic        ed;
      int          n;
      logic        busy_ok;
      model(op, a, b, eh, el, ed);
      bus_if.start = 1'b1;
      bus_if.op    = op;
      bus_if.a     = a;
      bus_if.b     = b;
      n       = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         n++;
         bus_if.start = 1'b0;
         bus_if.a     = $urandom;
         bus_if.b     = $urandom;
         if (!bus_if.done && !bus_if.busy) busy_ok = 1'b0;
      end while (!bus_if.done && n < 200);
      check({tag, " latency"}, 32'(n), 32'(exp_latency(op)));
      check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " hi"}, bus_if.hi, eh);
      check({tag, " lo"}, bus_if.lo, el);
      check({tag, " dbz"}, {31'd0, bus_if.dbz}, {31'd0, ed});
   endtask

   initial begin
      logic [31:0] eh, el;
      logic        ed;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          n;
      logic        seen;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_if.start = 1'b0;
      bus_if.op    = 2'b00;
      bus_if.a     = '0;
      bus_if.b     = '0;
      bus_if.hi_we = 1'b0;
      bus_if.lo_we = 1'b0;
      bus_if.wdata = '0;

      repeat (3) @(negedge clk);
      check("reset hi", bus_if.hi, 32'd0);
      check("reset lo", bus_if.lo, 32'd0);
      check("reset busy", {31'd0, bus_if.busy}, 32'd0);
      check("reset done", {31'd0, bus_if.done}, 32'd0);
      check("reset dbz", {31'd0, bus_if.dbz}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      check("div -7/2 lo const", bus_if.lo, 32'hFFFF_FFFD);
      check("div -7/2 hi const", bus_if.hi, 32'hFFFF_FFFF);
      @(negedge clk);
      check("done one cycle", {31'd0, bus_if.done}, 32'd0);

      do_op("mult min*-1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      check("mult min*-1 hi const", bus_if.hi, 32'h0000_0000);
      check("mult min*-1 lo const", bus_if.lo, 32'h8000_0000);
      do_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu max*max hi const", bus_if.hi, 32'hFFFF_FFFE);
      check("multu max*max lo const", bus_if.lo, 32'h0000_0001);

      do_op("divu 100/0", 2'b11, 32'h64, 32'd0);
      check("divu 100/0 dbz const", {31'd0, bus_if.dbz}, 32'd1);
      @(negedge clk);
      check("dbz one cycle", {31'd0, bus_if.dbz}, 32'd0);
      do_op("div 100/7", 2'b10, 32'd100, 32'd7);
      check("div 100/7 lo const", bus_if.lo, 32'd14);
      check("div 100/7 hi const", bus_if.hi, 32'd2);

      // Start and MTHI while busy must both be dropped.
      model(2'b11, 32'd1000, 32'd3, eh, el, ed);
      bus_if.start = 1'b1;
      bus_if.op    = 2'b11;
      bus_if.a     = 32'd1000;
      bus_if.b     = 32'd3;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.op    = 2'b00;
      bus_if.a     = 32'd5;
      bus_if.b     = 32'd6;
      bus_if.hi_we = 1'b1;
      bus_if.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.hi_we = 1'b0;
      n = 0;
      while (!bus_if.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("busy ignore done seen", {31'd0, bus_if.done}, 32'd1);
      check("busy ignore hi", bus_if.hi, eh);
      check("busy ignore lo", bus_if.lo, el);
      @(negedge clk);
      check("busy ignore no queue", {31'd0, bus_if.busy}, 32'd0);

      bus_if.lo_we = 1'b1;
      bus_if.wdata = 32'h0000_1234;
      @(negedge clk);
      bus_if.lo_we = 1'b0;
      check("mtlo lo", bus_if.lo, 32'h0000_1234);
      check("mtlo hi kept", bus_if.hi, eh);

      // Abort mid-run: outputs clear asynchronously and no done follows.
      bus_if.start = 1'b1;
      bus_if.op    = 2'b11;
      bus_if.a     = 32'hFFFF_FFFF;
      bus_if.b     = 32'd3;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort hi", bus_if.hi, 32'd0);
      check("abort lo", bus_if.lo, 32'd0);
      check("abort busy", {31'd0, bus_if.busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) seen = 1'b1;
      end
      check("abort no done", {31'd0, seen}, 32'd0);
      do_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div min/-1 lo const", bus_if.lo, 32'h8000_0000);
      check("div min/-1 hi const", bus_if.hi, 32'h0000_0000);

      // Back-to-back random regression: each start lands in the previous done cycle.
      for (int i = 0; i < 100; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
